hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameters SHALL be: RUN_CYCLES, default 34, number of consecutive cycles DIVU is held on div_signal; W, default 32, operand width.
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low; clears all state.
REQ-004 Port op_valid, input, 1: an instruction is present on funct this cycle.
REQ-005 Port funct, input, 6: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, DIVU 011011; other codes are ignored.
REQ-006 Port rs_data, input, W: dividend for DIVU, or write data for MTHI/MTLO.
REQ-007 Port rt_data, input, W: divisor for DIVU.
REQ-008 Port stall, output, 1: pipeline hold request.
REQ-009 Port rd_data, output, W: MFHI/MFLO read result.
REQ-010 Port div_reset, output, 1: active-high synchronous reset to the divider.
REQ-011 Port div_signal, output, 6: command to the divider; DIVU 011011 or PAUSE 000000.
REQ-012 Ports div_a and div_b, outputs, W each: divider dividend and divisor.
REQ-013 Port div_out, input, 2W: divider result; remainder in [63:32], quotient in [31:0].

Function
REQ-014 The block SHALL implement the FSM states INIT, IDLE, RUN, DRAIN and CAPTURE.
REQ-015 INIT SHALL drive div_reset=1 for exactly one cycle and then go to IDLE.
REQ-016 In IDLE, op_valid with DIVU and rt_data!=0 SHALL latch rs_data into div_a and rt_data into div_b, clear the cycle counter, and go to RUN.
REQ-017 In IDLE, DIVU with rt_data==0 SHALL set HI=rs_data and LO=32'hFFFF_FFFF at that edge, stay in IDLE, and never drive the divider.
REQ-018 RUN SHALL drive div_signal=DIVU for exactly RUN_CYCLES cycles (counter 0..RUN_CYCLES-1) and then go to DRAIN.
REQ-019 DRAIN SHALL drive div_signal=PAUSE for one cycle and then go to CAPTURE.
REQ-020 CAPTURE SHALL load HI<=div_out[63:32] and LO<=div_out[31:0], then go to IDLE.
REQ-021 div_signal SHALL be PAUSE in every state except RUN.
REQ-022 div_a and div_b SHALL stay constant from the acceptance edge until the next acceptance.
REQ-023 MTHI/MTLO in IDLE SHALL write rs_data into HI/LO at the edge; in any other state they SHALL be stalled.
REQ-024 rd_data SHALL be combinational: HI when funct=MFHI, LO when funct=MFLO, otherwise 0.
REQ-025 stall SHALL be combinationally 1 when op_valid is set with any HI/LO funct and the state is not IDLE, or when the state is INIT; otherwise stall SHALL be 0.
REQ-026 A stalled op SHALL have no effect and SHALL be accepted in the first IDLE cycle it is still presented.
REQ-027 DIVU latency SHALL be 36 cycles from the acceptance edge (RUN 34 + DRAIN 1 + CAPTURE 1); MFHI SHALL read the new HI in the following cycle.
REQ-028 Back-to-back DIVU SHALL be accepted in the cycle immediately after CAPTURE.
REQ-029 Unrecognised funct codes and op_valid=0 SHALL leave all state unchanged.

Reset
REQ-030 While reset=0, the block SHALL hold: state=INIT, HI=0, LO=0, counter=0, div_a=0, div_b=0, div_signal=PAUSE, div_reset=1, stall=1.
REQ-031 Reset asserted mid-divide SHALL abort immediately; after release, the INIT pulse SHALL reinitialise the divider before any DIVU is issued.
REQ-032 Async assert/sync deassert synchronisation is outside this block; reset SHALL be used directly as the async clear.

Structure
REQ-033 Funct codes, PAUSE/DIVU command codes and the RUN_CYCLES default SHALL live in a shared package used by both the divider and this block.
REQ-034 The FSM state enumeration SHALL be local to this block.
REQ-035 One sub-module, hilo_regs (the HI/LO pair with write enables and a read mux), MAY be split out; the divider itself SHALL be instantiated outside this block.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- DIVU 100/7 -> stall high for 36 cycles; then MFHI=2 and MFLO=14.
- DIVU 0xFFFFFFFF/1 -> HI=0, LO=0xFFFFFFFF; div_signal=DIVU for exactly 34 consecutive cycles.
- DIVU 5/0 -> no stall; HI=5, LO=0xFFFFFFFF on the next cycle; div_signal stays PAUSE.
- MTHI 0xDEAD0001 issued while RUN -> stalled until IDLE, then written; the following MFHI returns 0xDEAD0001 unless a DIVU CAPTURE intervenes.
- reset=0 at RUN cycle 10 -> HI=LO=0 and div_signal=PAUSE immediately; after release, div_reset pulses for 1 cycle; a new DIVU 9/3 then gives LO=3, HI=0.
- Two DIVU back-to-back (20/6, then 50/5) -> second accepted the cycle after the first CAPTURE; final HI=0, LO=10.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared HI/LO and divider codes: funct encodings, divider commands,
// default divider run length and a HI/LO funct classifier.
package hilo_pkg;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [5:0] F_DIVU = 6'b011011;

  localparam logic [5:0] CMD_PAUSE = 6'b000000;
  localparam logic [5:0] CMD_DIVU  = 6'b011011;

  localparam int RUN_CYCLES_DEF = 34;

  function automatic logic is_hilo(
    input logic [5:0] f
  );
    return (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_DIVU);
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair with independent write enables and MFHI/MFLO read mux.
// Ports: clk, reset (async low), hi_we/lo_we, hi_d/lo_d, funct -> rd_data.
module hilo_regs
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] hi_d,
  input  logic [W-1:0] lo_d,
  input  logic [5:0]   funct,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      funct == F_MFHI: rd_data = hi;
      funct == F_MFLO: rd_data = lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO control: sequences an external multi-cycle divider for DIVU and
// handles MTHI/MTLO/MFHI/MFLO with a stall while the divider is busy.
// Ports: clk, reset (async low), op_valid, funct, rs_data, rt_data in;
// stall, rd_data, div_reset, div_signal, div_a, div_b out; div_out in.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int RUN_CYCLES = RUN_CYCLES_DEF,
  parameter int W          = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [5:0]     funct,
  input  logic [W-1:0]   rs_data,
  input  logic [W-1:0]   rt_data,
  output logic           stall,
  output logic [W-1:0]   rd_data,
  output logic           div_reset,
  output logic [5:0]     div_signal,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic [2*W-1:0] div_out
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  localparam int CW = $clog2(RUN_CYCLES + 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          start;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  hi_d;
  logic [W-1:0]  lo_d;
  logic          last;

  assign last = (cnt == CW'(RUN_CYCLES - 1));

  assign stall = (state == S_INIT) ||
                 (op_valid && is_hilo(funct) &&
                  (state != S_IDLE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      cnt   <= '0;
      div_a <= '0;
      div_b <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        cnt   <= '0;
        div_a <= rs_data;
        div_b <= rt_data;
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nxt        = state;
    div_reset  = 1'b0;
    div_signal = CMD_PAUSE;
    start      = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = div_out[2*W-1:W];
    lo_d       = div_out[W-1:0];
    unique case (state)
      S_INIT: begin
        div_reset = 1'b1;
        nxt       = S_IDLE;
      end
      S_IDLE: begin
        if (op_valid) begin
          unique case (1'b1)
            funct == F_DIVU: begin
              // Divide by zero never reaches the divider.
              if (rt_data != '0) begin
                start = 1'b1;
                nxt   = S_RUN;
              end else begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_d  = rs_data;
                lo_d  = '1;
              end
            end
            funct == F_MTHI: begin
              hi_we = 1'b1;
              hi_d  = rs_data;
            end
            funct == F_MTLO: begin
              lo_we = 1'b1;
              lo_d  = rs_data;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        div_signal = CMD_DIVU;
        if (last) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        nxt   = S_IDLE;
      end
      default: nxt = S_INIT;
    endcase
  end

  hilo_regs #(
    .W (W)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi_d    (hi_d),
    .lo_d    (lo_d),
    .funct   (funct),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with a behavioural divider that
// produces its result only after 34 DIVU command cycles.
module tb_hilo_ctrl;

  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MTHI = 6'b010001;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] MTLO = 6'b010011;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] PAUSE = 6'b000000;
  localparam int NRUN = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  funct = 6'b0;
  logic [31:0] rs_data = 32'b0;
  logic [31:0] rt_data = 32'b0;
  logic        stall;
  logic [31:0] rd_data;
  logic        div_reset;
  logic [5:0]  div_signal;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_out = 64'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .stall      (stall),
    .rd_data    (rd_data),
    .div_reset  (div_reset),
    .div_signal (div_signal),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_out    (div_out)
  );

  // Behavioural divider
  int dcnt = 0;
  always @(posedge clk) begin
    if (div_reset) begin
      dcnt    <= 0;
      div_out <= 64'b0;
    end else if (div_signal == DIVU) begin
      if (dcnt == NRUN - 1) begin
        dcnt <= 0;
        if (div_b != 0)
          div_out <= {div_a % div_b, div_a / div_b};
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        v;
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
    logic [31:0] rd;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.nm, act, e.v);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    op_valid = v;
    funct    = f;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  // Count consecutive stalled cycles (and DIVU command cycles among them)
  // starting at the next negedge; returns at the first unstalled negedge.
  task automatic wait_stall(output int n, output int nd);
    n  = 0;
    nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) return;
      n++;
      if (div_signal == DIVU) nd++;
    end
    check("stall_timeout", 32'd1, 32'd0);
  endtask

  // Issue DIVU a/b then MFHI/MFLO; check latency and result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input string tag, output int nd);
    int n;
    sb.push_back('{{tag, "_hi"}, a % b});
    sb.push_back('{{tag, "_lo"}, a / b});
    drive(1'b1, DIVU, a, b);
    @(negedge clk);
    check({tag, "_accept_stall"}, 32'(stall), 32'd0);
    drive(1'b1, MFHI, 32'h0, 32'h0);
    wait_stall(n, nd);
    check({tag, "_stall_cycles"}, n, 36);
    check({tag, "_div_a"}, div_a, a);
    check({tag, "_div_b"}, div_b, b);
    pop_check(rd_data);
    drive(1'b1, MFLO, 32'h0, 32'h0);
    @(negedge clk);
    pop_check(rd_data);
  endtask

  vec_t vt[12];
  int   n;
  int   nd;

  initial begin
    vt[0]  = '{1'b1, MFHI, 32'h0,        32'h0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, MTHI, 32'h11,       32'h0, 1'b0, 32'h0};
    vt[2]  = '{1'b1, MFHI, 32'h0,        32'h0, 1'b0, 32'h11};
    vt[3]  = '{1'b1, MTLO, 32'h22,       32'h0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, MFLO, 32'h0,        32'h0, 1'b0, 32'h22};
    vt[5]  = '{1'b0, MTHI, 32'h55,       32'h0, 1'b0, 32'h0};
    vt[6]  = '{1'b1, MFHI, 32'h0,        32'h0, 1'b0, 32'h11};
    vt[7]  = '{1'b1, 6'h3F, 32'h77,      32'h0, 1'b0, 32'h0};
    vt[8]  = '{1'b1, MFLO, 32'h0,        32'h0, 1'b0, 32'h22};
    vt[9]  = '{1'b1, DIVU, 32'd5,        32'h0, 1'b0, 32'h0};
    vt[10] = '{1'b1, MFHI, 32'h0,        32'h0, 1'b0, 32'd5};
    vt[11] = '{1'b1, MFLO, 32'h0,        32'h0, 1'b0, 32'hFFFF_FFFF};

    // Reset state
    #12;
    funct = MFHI;
    #1;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_div_reset", 32'(div_reset), 32'd1);
    check("rst_div_signal", 32'(div_signal), 32'(PAUSE));
    check("rst_div_a", div_a, 32'h0);
    check("rst_hi", rd_data, 32'h0);
    funct = 6'b0;

    // Release: exactly one INIT cycle
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("init_div_reset", 32'(div_reset), 32'd1);
    check("init_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("idle_div_reset", 32'(div_reset), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);

    // Single-cycle IDLE operations
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].f, vt[i].rs, vt[i].rt);
      sb.push_back('{$sformatf("vec%0d_rd", i), vt[i].rd});
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].st));
      check($sformatf("vec%0d_cmd", i), 32'(div_signal), 32'(PAUSE));
      pop_check(rd_data);
    end

    // 100 / 7
    run_div(32'd100, 32'd7, "d100_7", nd);
    check("d100_7_divu_cycles", nd, NRUN);

    // 0xFFFFFFFF / 1
    run_div(32'hFFFF_FFFF, 32'd1, "dmax_1", nd);
    check("dmax_1_divu_cycles", nd, NRUN);

    // MTHI held during a divide
    drive(1'b1, DIVU, 32'd40, 32'd3);
    drive(1'b1, MTHI, 32'hDEAD_0001, 32'h0);
    wait_stall(n, nd);
    check("mthi_stall_cycles", n, 36);
    sb.push_back('{"mthi_hi", 32'hDEAD_0001});
    sb.push_back('{"mthi_lo", 32'd13});
    drive(1'b1, MFHI, 32'h0, 32'h0);
    @(negedge clk);
    pop_check(rd_data);
    drive(1'b1, MFLO, 32'h0, 32'h0);
    @(negedge clk);
    pop_check(rd_data);

    // Reset at RUN cycle 10
    drive(1'b1, DIVU, 32'd1000, 32'd3);
    drive(1'b0, 6'b0, 32'h0, 32'h0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    funct = MFHI;
    #1;
    check("abort_div_signal", 32'(div_signal), 32'(PAUSE));
    check("abort_hi", rd_data, 32'h0);
    check("abort_div_reset", 32'(div_reset), 32'd1);
    funct = MFLO;
    #1;
    check("abort_lo", rd_data, 32'h0);
    funct = 6'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reinit_div_reset", 32'(div_reset), 32'd1);
    @(negedge clk);
    check("reinit_pulse_end", 32'(div_reset), 32'd0);
    run_div(32'd9, 32'd3, "d9_3", nd);

    // Back-to-back DIVU
    drive(1'b1, DIVU, 32'd20, 32'd6);
    drive(1'b1, DIVU, 32'd50, 32'd5);
    wait_stall(n, nd);
    check("b2b_first_stall", n, 36);
    sb.push_back('{"b2b_hi", 32'd0});
    sb.push_back('{"b2b_lo", 32'd10});
    drive(1'b1, MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b_second_accepted", 32'(div_signal), 32'(DIVU));
    check("b2b_div_a", div_a, 32'd50);
    wait_stall(n, nd);
    check("b2b_second_stall", n + 1, 36);
    pop_check(rd_data);
    drive(1'b1, MFLO, 32'h0, 32'h0);
    @(negedge clk);
    pop_check(rd_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
